// File: rtl/img_pkg.sv
// Shared types and helpers for the image frame packer.
// Holds the default marker word, the packer state enum and the RGB565 to quad converter.
package img_pkg;

    localparam logic [31:0] MARK_WORD_DEF = 32'hFF00_0000;

    typedef enum logic [1:0] {
        SEEK,
        MARK,
        PIX
    } state_t;

    // RRRRRGGG_GGGBBBBB -> 00000000_RRRRR000_GGGGGG00_BBBBB000
    function automatic logic [31:0] rgb565_to_quad(input logic [15:0] d);
        return {8'h00, d[15:11], 3'b000, d[10:5], 2'b00, d[4:0], 3'b000};
    endfunction

endpackage

// File: rtl/img_frame_packer_if.sv
// Pixel-in / word-out handshake bundle of the frame packer.
// Ports: in_valid/in_ready/in_data/in_sync (pixel side), out_valid/out_ready/out_data/out_last (FIFO side).
interface img_frame_packer_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sync;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output in_valid, in_data, in_sync, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_sync, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/img_out_reg.sv
// Single-entry valid/ready output register carrying a 32-bit word plus a last flag.
// Ports: clk, reset, ld_valid/ld_data/ld_last (load side), out_ready, load_en, out_valid/out_data/out_last.
module img_out_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    input  logic        out_ready,
    output logic        load_en,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last
);

    // Register is free when empty or being drained this cycle.
    assign load_en = !out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load_en) begin
            out_valid <= ld_valid;
            out_last  <= ld_valid && ld_last;
            if (ld_valid) begin
                out_data <= ld_data;
            end
        end
    end

endmodule

// File: rtl/img_frame_packer.sv
// Packs an RGB565 pixel stream into framed 32-bit quad words with start marker and last tag.
// Ports: clk, reset, bus (slave handshake bundle), frame_count, drop_count, short_frame.
module img_frame_packer
    import img_pkg::*;
#(
    parameter int          WIDTH     = 640,
    parameter int          HEIGHT    = 480,
    parameter logic [31:0] MARK_WORD = MARK_WORD_DEF
) (
    input  logic               clk,
    input  logic               reset,
    img_frame_packer_if.slave  bus,
    output logic [15:0]        frame_count,
    output logic [15:0]        drop_count,
    output logic               short_frame
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int CW   = $clog2(NPIX);

    state_t          state;
    state_t          state_nx;
    logic            sync_pend;
    logic [CW-1:0]   pix_cnt;
    logic            load_en;
    logic            rdy;
    logic            accept;
    logic            last_px;
    logic            ld_valid;
    logic [31:0]     ld_data;
    logic            ld_last;
    logic            clr_pend;
    logic            cnt_clr;
    logic            set_short;

    assign bus.in_ready = rdy;
    assign accept       = bus.in_valid && rdy;
    assign last_px      = (pix_cnt == CW'(NPIX - 1));

    always_comb begin
        state_nx  = state;
        rdy       = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = MARK_WORD;
        ld_last   = 1'b0;
        clr_pend  = 1'b0;
        cnt_clr   = 1'b0;
        set_short = 1'b0;
        unique case (state)
            SEEK: begin
                rdy = !reset;
                if (sync_pend || bus.in_sync) begin
                    state_nx = MARK;
                end
            end
            MARK: begin
                if (load_en) begin
                    ld_valid = 1'b1;
                    clr_pend = 1'b1;
                    cnt_clr  = 1'b1;
                    state_nx = PIX;
                end
            end
            PIX: begin
                rdy = load_en && !sync_pend;
                if (sync_pend) begin
                    // New frame started before this one completed.
                    set_short = 1'b1;
                    state_nx  = MARK;
                end else if (accept) begin
                    ld_valid = 1'b1;
                    ld_data  = rgb565_to_quad(bus.in_data);
                    ld_last  = last_px;
                    if (last_px) begin
                        state_nx = SEEK;
                    end
                end
            end
            default: state_nx = SEEK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SEEK;
            sync_pend   <= 1'b0;
            pix_cnt     <= '0;
            frame_count <= '0;
            drop_count  <= '0;
            short_frame <= 1'b0;
        end else begin
            state <= state_nx;
            // A sync coinciding with the marker load belongs to the next frame.
            if (bus.in_sync) begin
                sync_pend <= 1'b1;
            end else if (clr_pend) begin
                sync_pend <= 1'b0;
            end
            if (cnt_clr) begin
                pix_cnt <= '0;
            end else if (state == PIX && accept) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
            if (bus.out_valid && bus.out_ready && bus.out_last) begin
                frame_count <= frame_count + 16'd1;
            end
            if (state == SEEK && accept && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            if (set_short) begin
                short_frame <= 1'b1;
            end
        end
    end

    img_out_reg u_out (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .out_ready (bus.out_ready),
        .load_en   (load_en),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .out_last  (bus.out_last)
    );

endmodule

// File: doc/img_frame_packer.md
# img_frame_packer

Frame packer between the camera pixel stream and the 32-bit image read FIFO. It converts RGB565 pixels to the 32-bit quad format (00000000_RRRRR000_GGGGGG00_BBBBB000). It prefixes every frame with a marker word and tags the last pixel of each frame. It counts pixels so that the host-side EOF and any frame-length errors are derived in hardware rather than by the host.

## Interface
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- MARK_WORD, 32'hFF00_0000, frame-start marker word
- clk  in  1  bus clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  pixel present on in_data
- in_ready  out  1  pixel accepted when in_valid && in_ready
- in_data  in  16  RGB565 pixel, RRRRRGGG_GGGBBBBB
- in_sync  in  1  single-cycle start-of-frame pulse, independent of in_valid
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream (FIFO !full) accepts
- out_data  out  32  marker or quad pixel
- out_last  out  1  qualifies the final pixel word of a frame
- frame_count  out  16  completed frames, wraps at 2^16
- drop_count  out  16  pixels discarded while in SEEK, saturates at 16'hFFFF
- short_frame  out  1  sticky: a sync arrived before a frame completed

## Operation
- Output stage is a single register (out_valid/out_data/out_last). It loads when load_en = !out_valid || out_ready.
- sync_pend: set by in_sync. Cleared when MARK loads the marker. in_sync and clear in the same cycle leave it set.
- State SEEK:
  - in_ready=1; every accepted pixel is discarded and drop_count increments.
  - If sync_pend or in_sync is high, go to MARK.
- State MARK:
  - in_ready=0.
  - When load_en is high, load MARK_WORD with out_last=0, clear pix_cnt and sync_pend, and go to PIX.
- State PIX:
  - in_ready = load_en && !sync_pend.
  - On accept, load the converted pixel: {8'h00, d[15:11],3'b0, d[10:5],2'b0, d[4:0],3'b0}. pix_cnt increments.
  - If pix_cnt == WIDTH*HEIGHT-1 on accept, set out_last=1 and go to SEEK.
  - If sync_pend becomes set while in PIX, set short_frame, go to MARK, and do not emit out_last.
- frame_count increments on an output handshake with out_last=1.
- pix_cnt width is $clog2(WIDTH*HEIGHT).
- A pixel and in_sync in the same cycle:
  - In SEEK, the pixel is dropped.
  - In PIX, the pixel is accepted only if sync_pend was already clear. It belongs to the old frame, and the sync takes effect next cycle.
- Reset values:
  - in_ready=0 during reset, and 1 in SEEK after reset.
  - out_valid=0, out_data=0, out_last=0.
  - Counters and short_frame = 0; state=SEEK.
- Reset mid-frame discards the output register contents; no partial frame is resumed.

## Timing
- Sync to marker: the marker is valid 2 cycles after the in_sync pulse, assuming out_ready=1 and the block is in SEEK.
- Pixel accept to out_valid: 1 cycle.
- Throughput: 1 word/cycle while out_ready=1.
- Stall behaviour while out_valid && !out_ready:
  - out_data and out_last are held stable.
  - in_ready=0 in PIX.
- The last pixel's handshake and the MARK transition never overlap; at least one SEEK cycle separates frames.
- The frame_count update is visible the cycle after the last-word handshake.

## Structure
- Package img_pkg:
  - MARK_WORD default
  - state enum {SEEK, MARK, PIX}
  - function rgb565_to_quad
- Sub-module img_out_reg: the 32+1-bit valid/ready output register with load_en. It is reusable for other FIFO-facing stages.
- The FSM, counters and sync latch live in img_frame_packer.

## Test plan
- Basic frame, WIDTH=4, HEIGHT=2, out_ready=1: sync, then 8 pixels of 16'hF800. Expect 9 words: FF000000, then 00F80000 ×8. out_last only on the 8th pixel word; frame_count=1.
- Colour mapping: pixels 16'h07E0 and 16'h001F. Expect 0000FC00 and 000000F8.
- Backpressure: out_ready toggled 1/0 every cycle across a frame. Expect no word lost or duplicated, data stable while stalled, and the sequence identical to the basic frame.
- Pre-sync pixels: 5 pixels before the first sync. Expect drop_count=5, no output words, then a normal frame.
- Short frame: sync, 3 pixels, sync, 8 pixels. Expect short_frame=1 and no out_last after pixel 3. Then a second marker and a full frame; frame_count=1.
- Reset mid-frame: reset asserted after 4 pixels. Expect out_valid=0 immediately (asynchronous) and counters=0. A following sync plus 8 pixels produces a clean frame.
